// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle between an operand-issuing controller (master)
// and the bit-serial subtractor (slave).
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a_in, b_in, bin,
    input  busy, done, diff_out, bout, ovf
  );

  modport slave (
    input  start, a_in, b_in, bin,
    output busy, done, diff_out, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, LSB first, one bit per clock, using a
// single full-subtractor cell wrapped around one borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bw;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs plus the running borrow
  always_comb begin
    w_a        = r_a_sh[0];
    w_b        = r_b_sh[0];
    w_d        = w_a ^ w_b ^ r_brw;
    w_bw       = (~w_a & w_b) | (w_b & r_brw) | (~w_a & r_brw);
    w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
    w_accept   = (r_state == S_IDLE) && bus.start;
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    w_next_state = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        bus.busy     = 1'b1;
        bus.done     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, serial shifting and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= bus.a_in;
      r_b_sh <= bus.b_in;
      r_brw  <= bus.bin;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_res_sh <= w_res_next;
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_brw    <= w_bw;
      if (w_last) begin
        // On the last bit the shifters hold the operand MSBs, so the
        // signed-overflow test can use them directly alongside w_d.
        r_cnt  <= '0;
        r_diff <= w_res_next;
        r_bout <= w_bw;
        r_ovf  <= (w_a != w_b) && (w_d != w_a);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.diff_out = r_diff;
  assign bus.bout     = r_bout;
  assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation: drive start for one edge, scramble the operands
  // afterwards, then look for done and check latency, result and pulse width.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb,
                        input logic eo);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.bin   = bi;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = ~b;
    bus.bin   = ~bi;
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (bus.done) begin
        lat = j;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"},  32'(lat), 32'd8);
    chk({tag, "_diff"}, 32'(bus.diff_out), 32'(ed));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    chk({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_donew"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"},  32'(bus.diff_out), 32'(ed));
  endtask

  logic [7:0] e_diff [3];
  logic       e_bout [3];
  logic       e_ovf  [3];

  initial begin
    int ndone;
    int first;
    logic [7:0] cap_diff;
    logic cap_bout, cap_ovf;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff_out), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Basic and boundary vectors
    run_op("t1",   8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0);
    run_op("t2a",  8'h05,  8'h09,  1'b0, 8'hFC,  1'b1, 1'b0);
    run_op("t2b",  8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0);
    run_op("t3",   8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1);
    run_op("t3b",  8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1);
    run_op("t3c",  8'hAA,  8'h55,  1'b1, 8'h54,  1'b0, 1'b1);

    // Second start 3 cycles into an op must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h80;
    bus.b_in  = 8'h01;
    bus.bin   = 1'b0;
    ndone = 0;
    first = -1;
    cap_diff = '0;
    cap_bout = 1'b0;
    cap_ovf  = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (t == 0) bus.start = 1'b0;
      if (t == 2) begin
        bus.start = 1'b1;
        bus.a_in  = 8'h01;
        bus.b_in  = 8'h01;
        bus.bin   = 1'b1;
      end
      if (t == 3) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first < 0) begin
          first    = t;
          cap_diff = bus.diff_out;
          cap_bout = bus.bout;
          cap_ovf  = bus.ovf;
        end
      end
    end
    chk("t4_ndone", 32'(ndone), 32'd1);
    chk("t4_lat",   32'(first), 32'd8);
    chk("t4_diff",  32'(cap_diff), 32'h7F);
    chk("t4_bout",  32'(cap_bout), 32'd0);
    chk("t4_ovf",   32'(cap_ovf), 32'd1);
    chk("t4_hold",  32'(bus.diff_out), 32'h7F);

    // Reset asserted mid-SHIFT (cnt=4) aborts the op
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'd100;
    bus.b_in  = 8'd37;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_diff", 32'(bus.diff_out), 32'd0);
    chk("t5_bout", 32'(bus.bout), 32'd0);
    chk("t5_ovf",  32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t5_nodone", 32'(ndone), 32'd0);
    run_op("t5_new", 8'h05, 8'h09, 1'b0, 8'hFC, 1'b1, 1'b0);

    // start held high: three back-to-back ops, operands changed after each accept
    e_diff[0] = 8'hF0; e_bout[0] = 1'b1; e_ovf[0] = 1'b0;
    e_diff[1] = 8'h63; e_bout[1] = 1'b0; e_ovf[1] = 1'b1;
    e_diff[2] = 8'hFF; e_bout[2] = 1'b1; e_ovf[2] = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 8'h10;
    bus.b_in  = 8'h20;
    bus.bin   = 1'b0;
    ndone = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t == 0) begin
        bus.a_in = 8'hC8; bus.b_in = 8'h64; bus.bin = 1'b1;
      end
      if (t == 10) begin
        bus.a_in = 8'h33; bus.b_in = 8'h33; bus.bin = 1'b1;
      end
      if (t == 20) begin
        bus.start = 1'b0;
        bus.a_in = 8'h5A; bus.b_in = 8'hA5; bus.bin = 1'b0;
      end
      if (bus.done) begin
        if (ndone < 3) begin
          chk($sformatf("t6_time%0d", ndone), 32'(t), 32'(8 + 10 * ndone));
          chk($sformatf("t6_diff%0d", ndone), 32'(bus.diff_out), 32'(e_diff[ndone]));
          chk($sformatf("t6_bout%0d", ndone), 32'(bus.bout), 32'(e_bout[ndone]));
          chk($sformatf("t6_ovf%0d",  ndone), 32'(bus.ovf), 32'(e_ovf[ndone]));
        end
        ndone++;
      end
    end
    chk("t6_ndone", 32'(ndone), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
